// File: rtl/pipeline_control_irq_call_ex.sv
// Interrupt-call sequencer: fetches a two-word IDT entry (flags, handler) and
// optionally pushes the return PC onto the supervisor stack via the shared LSU port.
//
// state    | meaning
// IDLE     | waiting for iIRQ_START
// FLG_REQ  | requesting flag word at E
// FLG_WAIT | waiting for flag word
// HDL_REQ  | requesting handler word at E+4
// HDL_WAIT | waiting for handler word
// PSH_REQ  | requesting return-PC write at SPR-4
// PSH_WAIT | waiting for write ack
// DONE     | one-cycle finish pulse
module pipeline_control_irq_call_ex #(
   parameter int unsigned IRQ_NUM_W  = 7,
   parameter int unsigned ENTRY_LOG2 = 3,
   parameter int unsigned SAVE_MODE  = 2
) (
   input  logic                 iCLOCK,
   input  logic                 inRESET,
   input  logic                 iRESET_SYNC,
   input  logic [31:0]          iSYSREG_IDTR,
   input  logic [31:0]          iSYSREG_SPR,
   input  logic [31:0]          iRET_PC,
   input  logic                 iIRQ_START,
   input  logic [IRQ_NUM_W-1:0] iIRQ_NUM,
   output logic                 oBUSY,
   output logic                 oFINISH,
   output logic [31:0]          oFINISH_HUNDLER,
   output logic [31:0]          oFINISH_SPR,
   output logic                 oFAULT,
   output logic                 oLDST_USE,
   output logic                 oLDST_REQ,
   input  logic                 iLDST_BUSY,
   output logic [1:0]           oLDST_ORDER,
   output logic                 oLDST_RW,
   output logic [31:0]          oLDST_ADDR,
   output logic [31:0]          oLDST_DATA,
   input  logic                 iLDST_REQ,
   input  logic [31:0]          iLDST_DATA
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_FLG_REQ, ST_FLG_WAIT, ST_HDL_REQ,
      ST_HDL_WAIT, ST_PSH_REQ, ST_PSH_WAIT, ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] entry_q, entry_d;
   logic [31:0] spr_q, spr_d;
   logic [31:0] ret_pc_q, ret_pc_d;
   logic        flag1_q, flag1_d;
   logic [31:0] handler_q, handler_d;
   logic [31:0] res_spr_q, res_spr_d;
   logic        fault_q, fault_d;
   logic        push_en;

   assign push_en = (SAVE_MODE == 1) || ((SAVE_MODE == 2) && flag1_q);

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q   <= ST_IDLE;
         entry_q   <= '0;
         spr_q     <= '0;
         ret_pc_q  <= '0;
         flag1_q   <= 1'b0;
         handler_q <= '0;
         res_spr_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         entry_q   <= entry_d;
         spr_q     <= spr_d;
         ret_pc_q  <= ret_pc_d;
         flag1_q   <= flag1_d;
         handler_q <= handler_d;
         res_spr_q <= res_spr_d;
         fault_q   <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      entry_d   = entry_q;
      spr_d     = spr_q;
      ret_pc_d  = ret_pc_q;
      flag1_d   = flag1_q;
      handler_d = handler_q;
      res_spr_d = res_spr_q;
      fault_d   = fault_q;
      unique case (state_q)
         ST_IDLE: if (iIRQ_START) begin
            entry_d  = iSYSREG_IDTR + (32'(iIRQ_NUM) << ENTRY_LOG2);
            spr_d    = iSYSREG_SPR;
            ret_pc_d = iRET_PC;
            state_d  = ST_FLG_REQ;
         end
         ST_FLG_REQ:  if (!iLDST_BUSY) state_d = ST_FLG_WAIT;
         ST_FLG_WAIT: if (iLDST_REQ) begin
            flag1_d = iLDST_DATA[1];
            if (!iLDST_DATA[0]) begin
               // Invalid entry: report fault with the stack untouched.
               handler_d = '0;
               res_spr_d = spr_q;
               fault_d   = 1'b1;
               state_d   = ST_DONE;
            end else begin
               state_d = ST_HDL_REQ;
            end
         end
         ST_HDL_REQ:  if (!iLDST_BUSY) state_d = ST_HDL_WAIT;
         ST_HDL_WAIT: if (iLDST_REQ) begin
            handler_d = iLDST_DATA;
            res_spr_d = spr_q;
            fault_d   = 1'b0;
            state_d   = push_en ? ST_PSH_REQ : ST_DONE;
         end
         ST_PSH_REQ:  if (!iLDST_BUSY) state_d = ST_PSH_WAIT;
         ST_PSH_WAIT: if (iLDST_REQ) begin
            res_spr_d = spr_q - 32'd4;
            state_d   = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (iRESET_SYNC) begin
         state_d   = ST_IDLE;
         entry_d   = '0;
         spr_d     = '0;
         ret_pc_d  = '0;
         flag1_d   = 1'b0;
         handler_d = '0;
         res_spr_d = '0;
         fault_d   = 1'b0;
      end
   end

   always_comb begin
      oLDST_REQ  = 1'b0;
      oLDST_USE  = 1'b0;
      oLDST_RW   = 1'b0;
      oLDST_ADDR = '0;
      oLDST_DATA = '0;
      unique case (state_q)
         ST_FLG_REQ, ST_FLG_WAIT: begin
            oLDST_REQ  = (state_q == ST_FLG_REQ);
            oLDST_USE  = 1'b1;
            oLDST_ADDR = entry_q;
         end
         ST_HDL_REQ, ST_HDL_WAIT: begin
            oLDST_REQ  = (state_q == ST_HDL_REQ);
            oLDST_USE  = 1'b1;
            oLDST_ADDR = entry_q + 32'd4;
         end
         ST_PSH_REQ, ST_PSH_WAIT: begin
            oLDST_REQ  = (state_q == ST_PSH_REQ);
            oLDST_USE  = 1'b1;
            oLDST_RW   = 1'b1;
            oLDST_ADDR = spr_q - 32'd4;
            oLDST_DATA = ret_pc_q;
         end
         default: ;
      endcase
   end

   assign oBUSY           = (state_q != ST_IDLE);
   assign oFINISH         = (state_q == ST_DONE);
   assign oFINISH_HUNDLER = handler_q;
   assign oFINISH_SPR     = res_spr_q;
   assign oFAULT          = fault_q;
   assign oLDST_ORDER     = 2'b10;

endmodule

// File: tb/tb_pipeline_control_irq_call_ex.sv
// Bench for pipeline_control_irq_call_ex: table of IRQ calls run back to back
// against a responding LSU model, plus a hand-written abort sequence.
module tb_pipeline_control_irq_call_ex;

   logic        iCLOCK = 1'b0;
   logic        inRESET = 1'b0;
   logic        iRESET_SYNC = 1'b0;
   logic [31:0] iSYSREG_IDTR = '0;
   logic [31:0] iSYSREG_SPR = '0;
   logic [31:0] iRET_PC = '0;
   logic        iIRQ_START = 1'b0;
   logic [6:0]  iIRQ_NUM = '0;
   logic        oBUSY, oFINISH, oFAULT, oLDST_USE, oLDST_REQ, oLDST_RW;
   logic [31:0] oFINISH_HUNDLER, oFINISH_SPR, oLDST_ADDR, oLDST_DATA;
   logic [1:0]  oLDST_ORDER;
   logic        iLDST_BUSY = 1'b0;
   logic        iLDST_REQ = 1'b0;
   logic [31:0] iLDST_DATA = '0;

   always #5 iCLOCK = ~iCLOCK;

   pipeline_control_irq_call_ex #(
      .IRQ_NUM_W(7), .ENTRY_LOG2(3), .SAVE_MODE(2)
   ) dut (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
      .iSYSREG_IDTR(iSYSREG_IDTR), .iSYSREG_SPR(iSYSREG_SPR), .iRET_PC(iRET_PC),
      .iIRQ_START(iIRQ_START), .iIRQ_NUM(iIRQ_NUM),
      .oBUSY(oBUSY), .oFINISH(oFINISH), .oFINISH_HUNDLER(oFINISH_HUNDLER),
      .oFINISH_SPR(oFINISH_SPR), .oFAULT(oFAULT),
      .oLDST_USE(oLDST_USE), .oLDST_REQ(oLDST_REQ), .iLDST_BUSY(iLDST_BUSY),
      .oLDST_ORDER(oLDST_ORDER), .oLDST_RW(oLDST_RW), .oLDST_ADDR(oLDST_ADDR),
      .oLDST_DATA(oLDST_DATA), .iLDST_REQ(iLDST_REQ), .iLDST_DATA(iLDST_DATA)
   );

   typedef struct {
      logic [31:0] idtr;
      logic [6:0]  num;
      logic [31:0] spr;
      logic [31:0] ret_pc;
      logic [31:0] flags;
      logic [31:0] handler;
      int          busy_flg;
      int          ackx_flg;
      logic [31:0] exp_entry;
      logic [31:0] exp_hdl;
      logic [31:0] exp_spr;
      logic        exp_fault;
      int          exp_cyc;
   } vec_t;

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } acc_t;

   typedef struct {
      logic [31:0] hdl;
      logic [31:0] spr;
      logic        fault;
      int          cyc;
   } res_t;

   acc_t acc_q[$];
   res_t res_q[$];
   vec_t vecs[7];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"},   32'(oBUSY), 32'd0);
      chk({tag, "_finish"}, 32'(oFINISH), 32'd0);
      chk({tag, "_hdl"},    oFINISH_HUNDLER, 32'd0);
      chk({tag, "_spr"},    oFINISH_SPR, 32'd0);
      chk({tag, "_fault"},  32'(oFAULT), 32'd0);
      chk({tag, "_use"},    32'(oLDST_USE), 32'd0);
      chk({tag, "_req"},    32'(oLDST_REQ), 32'd0);
      chk({tag, "_rw"},     32'(oLDST_RW), 32'd0);
      chk({tag, "_addr"},   oLDST_ADDR, 32'd0);
      chk({tag, "_data"},   oLDST_DATA, 32'd0);
   endtask

   // Called at a negedge; drives the start in that cycle (cycle 0).
   task automatic run_vec(input vec_t v);
      acc_t a, cur;
      res_t r, got;
      int   cyc, busy_left, wait_cnt, ackx;
      bit   done, pending, in_wait;
      a = '{1'b0, v.exp_entry, 32'h0, v.flags};
      acc_q.push_back(a);
      if (v.flags[0]) begin
         a = '{1'b0, v.exp_entry + 32'd4, 32'h0, v.handler};
         acc_q.push_back(a);
         if (v.flags[1]) begin
            a = '{1'b1, v.spr - 32'd4, v.ret_pc, 32'h0};
            acc_q.push_back(a);
         end
      end
      r = '{v.exp_hdl, v.exp_spr, v.exp_fault, v.exp_cyc};
      res_q.push_back(r);

      iIRQ_START   = 1'b1;
      iSYSREG_IDTR = v.idtr;
      iIRQ_NUM     = v.num;
      iSYSREG_SPR  = v.spr;
      iRET_PC      = v.ret_pc;
      cyc = 0; done = 0; pending = 0; in_wait = 0; wait_cnt = 0;
      busy_left = v.busy_flg; ackx = v.ackx_flg;
      cur = '{1'b0, 32'h0, 32'h0, 32'h0};
      while (!done && cyc < 40) begin
         @(negedge iCLOCK);
         cyc++;
         iLDST_BUSY = 1'b0;
         iLDST_REQ  = 1'b0;
         iLDST_DATA = '0;
         // Inputs change after cycle 0 and start lingers: both must be ignored.
         if (cyc == 1) begin
            iSYSREG_IDTR = ~v.idtr;
            iSYSREG_SPR  = ~v.spr;
            iRET_PC      = ~v.ret_pc;
            iIRQ_NUM     = ~v.num;
         end
         if (cyc == 3) iIRQ_START = 1'b0;
         if (in_wait) begin
            chk("use_in_wait", 32'({oLDST_USE, oLDST_REQ}), 32'b10);
            if (wait_cnt >= ackx) begin
               iLDST_REQ  = 1'b1;
               iLDST_DATA = cur.rdata;
               in_wait    = 0;
               ackx       = 0;
            end else begin
               wait_cnt++;
            end
         end
         if (oLDST_REQ) begin
            if (!pending) begin
               if (acc_q.size() == 0) begin
                  chk("unexpected_access", oLDST_ADDR, 32'hFFFF_FFFF);
                  cur = '{oLDST_RW, oLDST_ADDR, oLDST_DATA, 32'h0};
               end else begin
                  cur = acc_q.pop_front();
                  chk("acc_addr",  oLDST_ADDR, cur.addr);
                  chk("acc_rw",    32'(oLDST_RW), 32'(cur.rw));
                  chk("acc_wdata", oLDST_DATA, cur.wdata);
                  chk("acc_order", 32'(oLDST_ORDER), 32'd2);
                  chk("acc_use",   32'(oLDST_USE), 32'd1);
               end
               pending = 1;
            end else begin
               chk("held_addr", oLDST_ADDR, cur.addr);
               chk("held_data", oLDST_DATA, cur.wdata);
            end
            if (busy_left > 0) begin
               iLDST_BUSY = 1'b1;
               busy_left--;
            end else begin
               pending  = 0;
               in_wait  = 1;
               wait_cnt = 0;
            end
         end else if (pending) begin
            chk("req_dropped", 32'(oLDST_REQ), 32'd1);
            pending = 0;
         end
         if (oFINISH) begin
            done = 1;
            got = res_q.pop_front();
            chk("fin_hdl",   oFINISH_HUNDLER, got.hdl);
            chk("fin_spr",   oFINISH_SPR, got.spr);
            chk("fin_fault", 32'(oFAULT), 32'(got.fault));
            chk("fin_cycle", 32'(cyc), 32'(got.cyc));
            chk("fin_busy",  32'(oBUSY), 32'd1);
            chk("fin_use",   32'(oLDST_USE), 32'd0);
         end
      end
      if (!done) begin
         chk("finish_timeout", 32'(cyc), 32'(v.exp_cyc));
         res_q.delete();
      end
      chk("leftover_access", 32'(acc_q.size()), 32'd0);
      acc_q.delete();
      iIRQ_START = 1'b0;
      @(negedge iCLOCK);
      iLDST_REQ = 1'b0;
      chk("post_busy",   32'(oBUSY), 32'd0);
      chk("post_finish", 32'(oFINISH), 32'd0);
      chk("post_hold",   oFINISH_HUNDLER, v.exp_hdl);
   endtask

   initial begin
      //            idtr          num    spr           ret_pc        flags         handler       bsy ack entry         exp_hdl       exp_spr       flt cyc
      vecs[0] = '{32'h0000_1000, 7'd5,  32'h0000_3000, 32'h0000_AAAA, 32'h0000_0001, 32'h8000_0040, 0, 0, 32'h0000_1028, 32'h8000_0040, 32'h0000_3000, 1'b0, 5};
      vecs[1] = '{32'h0000_4000, 7'd2,  32'h0000_2000, 32'h0000_1234, 32'h0000_0003, 32'h0000_1100, 0, 0, 32'h0000_4010, 32'h0000_1100, 32'h0000_1FFC, 1'b0, 7};
      vecs[2] = '{32'h0000_1000, 7'h7F, 32'h0000_5000, 32'h0000_0001, 32'h0000_0000, 32'hBAD0_0000, 0, 0, 32'h0000_13F8, 32'h0000_0000, 32'h0000_5000, 1'b1, 3};
      vecs[3] = '{32'h8000_0000, 7'h10, 32'h0000_6000, 32'h0000_0002, 32'h0000_0002, 32'hBAD0_0001, 0, 0, 32'h8000_0080, 32'h0000_0000, 32'h0000_6000, 1'b1, 3};
      vecs[4] = '{32'h0000_1000, 7'd5,  32'h0000_3000, 32'h0000_AAAA, 32'h0000_0001, 32'h8000_0040, 3, 1, 32'h0000_1028, 32'h8000_0040, 32'h0000_3000, 1'b0, 9};
      vecs[5] = '{32'h0000_0000, 7'h40, 32'h0000_0010, 32'h0000_0003, 32'hF000_0001, 32'h1234_5678, 0, 0, 32'h0000_0200, 32'h1234_5678, 32'h0000_0010, 1'b0, 5};
      vecs[6] = '{32'hFFFF_FFF8, 7'd1,  32'h0000_0000, 32'h0000_CAFE, 32'h0000_0003, 32'h4000_0000, 0, 0, 32'h0000_0000, 32'h4000_0000, 32'hFFFF_FFFC, 1'b0, 7};

      #12;
      chk_idle_zero("reset");
      @(negedge iCLOCK);
      inRESET = 1'b1;
      @(negedge iCLOCK);
      chk_idle_zero("after_reset");

      foreach (vecs[i]) run_vec(vecs[i]);

      // Abort in HDL_WAIT; a late ack must not revive the sequence.
      iIRQ_START = 1'b1; iSYSREG_IDTR = 32'h0000_6000; iIRQ_NUM = 7'd3;
      iSYSREG_SPR = 32'h0000_7000; iRET_PC = 32'h0000_0055;
      @(negedge iCLOCK);
      iIRQ_START = 1'b0;
      chk("abort_flg_addr", oLDST_ADDR, 32'h0000_6018);
      @(negedge iCLOCK);
      iLDST_REQ = 1'b1; iLDST_DATA = 32'h0000_0003;
      @(negedge iCLOCK);
      iLDST_REQ = 1'b0; iLDST_DATA = '0;
      chk("abort_hdl_addr", oLDST_ADDR, 32'h0000_601C);
      @(negedge iCLOCK);
      chk("abort_in_wait", 32'({oLDST_USE, oLDST_REQ}), 32'b10);
      iRESET_SYNC = 1'b1;
      @(negedge iCLOCK);
      iRESET_SYNC = 1'b0;
      chk_idle_zero("abort");
      iLDST_REQ = 1'b1; iLDST_DATA = 32'hDEAD_BEEF;
      @(negedge iCLOCK);
      iLDST_REQ = 1'b0; iLDST_DATA = '0;
      chk("late_ack_busy", 32'(oBUSY), 32'd0);
      chk("late_ack_hdl",  oFINISH_HUNDLER, 32'd0);
      chk("late_ack_use",  32'(oLDST_USE), 32'd0);
      run_vec(vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
